fp16_div: RTL and testbench



---
 rtl/fp16_div.sv | 177 +++++++++++++++++
 tb/tb_fp16_div.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_div.sv
// fp16_div -- iterative IEEE-754 half-precision divider (data1 / data2).
// One operation in flight; fixed 14-cycle latency from accept to result.
// Numeric behaviour: saturate on overflow or Inf/NaN/zero/subnormal divisor,
// flush subnormal dividends and underflow to +0, round-to-nearest-even.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; aborts any operation
//   data1          dividend (FP16), sampled with input_valid in IDLE
//   data2          divisor  (FP16), sampled with input_valid in IDLE
//   input_valid    operand strobe; ignored while busy
//   datanew        result register, holds last result
//   output_update  one-cycle pulse when datanew is written
//   busy           high while an operation is in flight
module fp16_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic        input_valid,
  output logic [15:0] datanew,
  output logic        output_update,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, ROUND} state_t;
  typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_SAT} cls_t;

  state_t      state, state_nxt;
  logic [15:0] op_a, op_b;
  logic        sign;
  logic [6:0]  e;       // biased exponent, 7-bit two's complement
  logic [10:0] m2;
  logic [12:0] r;       // partial remainder
  logic [11:0] q;
  logic [3:0]  cnt;
  cls_t        cls;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (input_valid) state_nxt = PREP;
      PREP:    state_nxt = DIV;
      DIV:     if (cnt == 4'd11) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------- PREP: align mantissas, classify ----------------
  logic [4:0]  ea, eb;
  logic [10:0] m1_pre, m2_pre;
  logic [6:0]  e_pre;
  logic [12:0] r_pre;
  logic [6:0]  e_adj;
  cls_t        cls_pre;

  always_comb begin
    ea     = op_a[14:10];
    eb     = op_b[14:10];
    m1_pre = {1'b1, op_a[9:0]};
    m2_pre = {1'b1, op_b[9:0]};
    e_pre  = {2'b00, ea} - {2'b00, eb} + 7'd15;
    // Pre-shift the dividend so the quotient lands in [1,2) and q[11] is set.
    if (m1_pre < m2_pre) begin
      r_pre = {1'b0, m1_pre, 1'b0};
      e_adj = e_pre - 7'd1;
    end else begin
      r_pre = {2'b00, m1_pre};
      e_adj = e_pre;
    end
    if (ea == 5'd31 || eb == 5'd31 || op_b[14:0] == 15'd0 || eb == 5'd0)
      cls_pre = CLS_SAT;
    else if (ea == 5'd0)
      cls_pre = CLS_ZERO;
    else
      cls_pre = CLS_NORMAL;
  end

  // ---------------- DIV: one restoring step per cycle ----------------
  logic        q_bit;
  logic [12:0] r_sub, r_nxt;

  always_comb begin
    q_bit = (r >= {2'b00, m2});
    r_sub = q_bit ? (r - {2'b00, m2}) : r;
    r_nxt = {r_sub[11:0], 1'b0};
  end

  // ---------------- ROUND: RNE and result packing ----------------
  logic        guard, sticky, inc;
  logic [11:0] mant_sum;
  logic [10:0] mant_fin;
  logic [6:0]  e_fin;
  logic [15:0] result;

  always_comb begin
    guard    = q[0];
    sticky   = (r != 13'd0);
    inc      = guard & (q[1] | sticky);
    mant_sum = {1'b0, q[11:1]} + {11'd0, inc};
    if (mant_sum[11]) begin
      mant_fin = 11'h400;
      e_fin    = e + 7'd1;
    end else begin
      mant_fin = mant_sum[10:0];
      e_fin    = e;
    end
    if (cls == CLS_SAT)
      result = {sign, 15'h7FFF};
    else if (cls == CLS_ZERO)
      result = 16'h0000;
    else if (!e_fin[6] && e_fin >= 7'd31)
      result = {sign, 15'h7FFF};
    else if (e_fin[6] || e_fin == 7'd0)
      result = 16'h0000;
    else
      result = {sign, e_fin[4:0], mant_fin[9:0]};
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a          <= '0;
      op_b          <= '0;
      sign          <= 1'b0;
      e             <= '0;
      m2            <= '0;
      r             <= '0;
      q             <= '0;
      cnt           <= '0;
      cls           <= CLS_NORMAL;
      datanew       <= 16'h0000;
      output_update <= 1'b0;
    end else begin
      output_update <= 1'b0;
      case (state)
        IDLE: if (input_valid) begin
          op_a <= data1;
          op_b <= data2;
        end
        PREP: begin
          sign <= op_a[15] ^ op_b[15];
          e    <= e_adj;
          m2   <= m2_pre;
          r    <= r_pre;
          q    <= '0;
          cnt  <= '0;
          cls  <= cls_pre;
        end
        DIV: begin
          r   <= r_nxt;
          q   <= {q[10:0], q_bit};
          cnt <= cnt + 4'd1;
        end
        ROUND: begin
          datanew       <= result;
          output_update <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div.sv
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data1, data2;
  logic        input_valid;
  logic [15:0] datanew;
  logic        output_update;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  fp16_div dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2),
    .input_valid(input_valid), .datanew(datanew),
    .output_update(output_update), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: real quotient of the significands computed by integer long
  // division, then round-to-nearest-even on the 11-bit result.
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, num, qq, rem, mant;
    logic s;
    logic [15:0] res;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 31 || eb == 31 || eb == 0) return {s, 15'h7FFF};
    if (ea == 0) return 16'h0000;
    ma = 1024 + int'(a[9:0]);
    mb = 1024 + int'(b[9:0]);
    e  = ea - eb + 15;
    if (ma < mb) begin ma = ma * 2; e = e - 1; end
    num  = ma * 2048;
    qq   = num / mb;
    rem  = num % mb;
    mant = qq / 2;
    if ((qq % 2 == 1) && ((mant % 2 == 1) || rem != 0)) mant = mant + 1;
    if (mant == 2048) begin mant = 1024; e = e + 1; end
    if (e >= 31) return {s, 15'h7FFF};
    if (e <= 0) return 16'h0000;
    res = {s, e[4:0], mant[9:0]};
    return res;
  endfunction

  // Accept at edge N, then require the result exactly at N+14.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string name);
    logic early;
    @(negedge clk);
    data1 = a; data2 = b; input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    check({name, " busy_after_accept"}, {15'd0, busy}, 16'd1);
    early = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
      if (output_update) early = 1'b1;
    end
    check({name, " no_early_update"}, {15'd0, early}, 16'd0);
    @(posedge clk); #1;
    check({name, " update_at_N14"}, {15'd0, output_update}, 16'd1);
    check({name, " busy_low_at_N14"}, {15'd0, busy}, 16'd0);
    check({name, " datanew"}, datanew, exp);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{16'h4200, 16'h3C00, 16'h4200, "3div1"};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, "1div3"};
    vecs[2]  = '{16'hC400, 16'h4000, 16'hC000, "neg4div2"};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7FFF, "div_by_zero"};
    vecs[4]  = '{16'h7C00, 16'h3C00, 16'h7FFF, "inf_dividend"};
    vecs[5]  = '{16'h3C00, 16'hFE00, 16'hFFFF, "nan_divisor_neg"};
    vecs[6]  = '{16'h0000, 16'h4000, 16'h0000, "zero_dividend"};
    vecs[7]  = '{16'h0200, 16'h3C00, 16'h0000, "subnormal_dividend"};
    vecs[8]  = '{16'h7BFF, 16'h3800, 16'h7FFF, "overflow_e31"};
    vecs[9]  = '{16'h0400, 16'h4000, 16'h0000, "underflow_e0"};
    vecs[10] = '{16'h3C00, 16'h8000, 16'hFFFF, "div_by_negzero"};

    rst = 1'b1; input_valid = 1'b0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset datanew", datanew, 16'h0000);
    check("reset update", {15'd0, output_update}, 16'd0);
    check("reset busy", {15'd0, busy}, 16'd0);

    // rst and input_valid together: operand must not be taken.
    @(negedge clk);
    data1 = 16'h4000; data2 = 16'h3C00; input_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_wins busy", {15'd0, busy}, 16'd0);
    rst = 1'b0; input_valid = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Randomized operands, biased toward normal exponents.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(3, 0) != 0) a[14:10] = 5'($urandom_range(30, 1));
      if ($urandom_range(3, 0) != 0) b[14:10] = 5'($urandom_range(30, 1));
      run_op(a, b, ref_div(a, b), $sformatf("rand%0d %h/%h", i, a, b));
    end

    // input_valid held high for 40 edges: accepts at 0, 15, 30.
    begin
      int pulses, prev, pos[$];
      pulses = 0; prev = 0;
      @(negedge clk);
      data1 = 16'h4200; data2 = 16'h3C00; input_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
        @(posedge clk); #1;
        if (k == 39) input_valid = 1'b0;
        if (output_update) begin
          pulses++;
          pos.push_back(k);
          if (prev) check("update_back_to_back", 16'd1, 16'd0);
        end
        prev = int'(output_update);
      end
      check("hold_valid pulses", 16'(pulses), 16'd3);
      if (pos.size() == 3) begin
        check("hold_valid pulse0", 16'(pos[0]), 16'd14);
        check("hold_valid pulse1", 16'(pos[1]), 16'd29);
        check("hold_valid pulse2", 16'(pos[2]), 16'd44);
      end
    end

    // Extra input_valid at N+5 is dropped.
    begin
      int pulses, at;
      pulses = 0; at = -1;
      @(negedge clk);
      data1 = 16'h4000; data2 = 16'h4000; input_valid = 1'b1;
      for (int k = 0; k < 32; k++) begin
        @(posedge clk); #1;
        input_valid = 1'b0;
        if (k == 4) begin data1 = 16'h4400; data2 = 16'h3C00; input_valid = 1'b1; end
        if (output_update) begin pulses++; at = k; end
      end
      check("busy_drop pulses", 16'(pulses), 16'd1);
      check("busy_drop pulse_at", 16'(at), 16'd14);
      check("busy_drop datanew", datanew, 16'h3C00);
    end

    // Reset at N+7 aborts; then a new op is taken at the following edge.
    run_op(16'h4200, 16'h3C00, 16'h4200, "pre_abort");
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      data1 = 16'h4400; data2 = 16'h3C00; input_valid = 1'b1;
      @(posedge clk); #1;                    // edge N
      input_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        if (output_update) pulses++;
      end
      rst = 1'b1;
      @(posedge clk); #1;                    // edge N+7
      if (output_update) pulses++;
      check("abort datanew", datanew, 16'h0000);
      check("abort busy", {15'd0, busy}, 16'd0);
      rst = 1'b0;
      data1 = 16'h4000; data2 = 16'h4000; input_valid = 1'b1;
      @(posedge clk); #1;                    // accept edge
      input_valid = 1'b0;
      check("post_abort busy", {15'd0, busy}, 16'd1);
      repeat (13) begin
        @(posedge clk); #1;
        if (output_update) pulses++;
      end
      check("abort no_pulse", 16'(pulses), 16'd0);
      @(posedge clk); #1;
      check("post_abort update", {15'd0, output_update}, 16'd1);
      check("post_abort datanew", datanew, 16'h3C00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
